// File: rtl/led_nios_mem_arbiter_if.sv
// Shared bus bundle between the two Avalon-MM masters, the arbiter and the RAM port.
// Purely combinational wiring; no storage.
// Back-pressure is carried by the per-master waitrequest signals.
interface led_nios_mem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] m0_address;
  logic [BE_W-1:0]   m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;

  logic [ADDR_W-1:0] m1_address;
  logic [BE_W-1:0]   m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  // Arbiter side: takes master requests and RAM q, drives responses and the RAM port.
  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata
  );

  // Environment side: the two masters plus the RAM model.
  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/led_nios_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two Avalon-MM masters.
// Latency: writes complete in the grant cycle; reads return readdatavalid one cycle after grant.
// Back-pressure: combinational waitrequest on the losing master; one access per cycle.
module led_nios_mem_arbiter #(
  parameter int          ADDR_W = 13,
  parameter int          DATA_W = 32,
  parameter int unsigned DEPTH  = 5000,
  parameter int          ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  led_nios_mem_arbiter_if.slave bus,
  output logic [ERR_W-1:0]  err_count
);
  localparam int BE_W = DATA_W / 8;
  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  logic              last_grant;
  logic              rd_vld;
  logic              rd_owner;
  logic              rd_oor;

  logic              req0;
  logic              req1;
  logic              grant0;
  logic              grant1;
  logic              any_grant;
  logic [ADDR_W-1:0] g_address;
  logic [BE_W-1:0]   g_byteenable;
  logic [DATA_W-1:0] g_writedata;
  logic              g_write;
  logic              g_read;
  logic              g_both;
  logic              g_oor;
  logic              err_inc;

  assign req0 = bus.m0_read | bus.m0_write;
  assign req1 = bus.m1_read | bus.m1_write;

  // Round-robin grant: on contention the master that did not win last time goes first.
  // Nothing is granted while reset is held so the RAM stays quiet.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      if (req0 && (!req1 || last_grant == OWNER_M1)) begin
        grant0 = 1'b1;
      end else if (req1) begin
        grant1 = 1'b1;
      end
    end
  end

  assign any_grant = grant0 | grant1;

  assign bus.m0_waitrequest = req0 & ~grant0;
  assign bus.m1_waitrequest = req1 & ~grant1;

  // Mux the granted master onto the RAM port; m0 is the default source when idle.
  always_comb begin
    g_address    = bus.m0_address;
    g_byteenable = bus.m0_byteenable;
    g_writedata  = bus.m0_writedata;
    g_write      = grant0 & bus.m0_write;
    g_read       = grant0 & bus.m0_read & ~bus.m0_write;
    g_both       = grant0 & bus.m0_read & bus.m0_write;
    if (grant1) begin
      g_address    = bus.m1_address;
      g_byteenable = bus.m1_byteenable;
      g_writedata  = bus.m1_writedata;
      g_write      = bus.m1_write;
      g_read       = bus.m1_read & ~bus.m1_write;
      g_both       = bus.m1_read & bus.m1_write;
    end
  end

  assign g_oor   = 32'(g_address) >= DEPTH;
  // Read+write together and out-of-range each count once per accepted access.
  assign err_inc = any_grant & (g_both | g_oor);

  assign bus.mem_address    = g_address;
  assign bus.mem_byteenable = g_byteenable;
  assign bus.mem_writedata  = g_writedata;
  assign bus.mem_chipselect = any_grant & ~g_oor;
  assign bus.mem_write      = g_write & ~g_oor;
  assign bus.mem_clken      = 1'b1;

  // Remember who gets the next grant priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= OWNER_M1;
    end else if (any_grant) begin
      last_grant <= grant1;
    end
  end

  // Track the read in flight so its data is routed to the right master next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld   <= 1'b0;
      rd_owner <= OWNER_M0;
      rd_oor   <= 1'b0;
    end else begin
      rd_vld   <= g_read;
      rd_owner <= grant1;
      rd_oor   <= g_oor;
    end
  end

  // Saturating error counter; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (err_inc && err_count != {ERR_W{1'b1}}) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

  assign bus.m0_readdatavalid = rd_vld & (rd_owner == OWNER_M0);
  assign bus.m1_readdatavalid = rd_vld & (rd_owner == OWNER_M1);
  // Out-of-range reads return zero; the non-owner always sees zero.
  assign bus.m0_readdata = (bus.m0_readdatavalid && !rd_oor) ? bus.mem_readdata : '0;
  assign bus.m1_readdata = (bus.m1_readdatavalid && !rd_oor) ? bus.mem_readdata : '0;
endmodule

// File: tb/tb_led_nios_mem_arbiter.sv
// Directed bench for led_nios_mem_arbiter with a behavioural single-port RAM.
// Inputs change on the falling edge; outputs are sampled 1 ns after it.
// A second instance with a 2-bit counter exercises saturation.
module tb_led_nios_mem_arbiter;
  logic clk;
  logic reset_n;
  logic [15:0] err_count;
  logic [1:0]  err_count_s;
  int checks;
  int errors;

  led_nios_mem_arbiter_if #(.ADDR_W(13), .DATA_W(32)) bus ();
  led_nios_mem_arbiter_if #(.ADDR_W(13), .DATA_W(32)) bus_s ();

  led_nios_mem_arbiter #(.ADDR_W(13), .DATA_W(32), .DEPTH(5000), .ERR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .err_count(err_count)
  );

  led_nios_mem_arbiter #(.ADDR_W(13), .DATA_W(32), .DEPTH(5000), .ERR_W(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .bus(bus_s.slave), .err_count(err_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered q, byte-lane writes, only active when selected.
  logic [31:0] ram [0:8191];
  logic [31:0] q;
  always @(posedge clk) begin
    if (bus.mem_chipselect && bus.mem_clken) begin
      if (bus.mem_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteenable[b]) ram[bus.mem_address][b*8 +: 8] <= bus.mem_writedata[b*8 +: 8];
      end
      q <= ram[bus.mem_address];
    end
  end
  assign bus.mem_readdata   = q;
  assign bus_s.mem_readdata = 32'h0;

  task automatic m0_set(input logic rd, input logic wr, input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a; bus.m0_byteenable = be; bus.m0_writedata = d;
  endtask

  task automatic m1_set(input logic rd, input logic wr, input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a; bus.m1_byteenable = be; bus.m1_writedata = d;
  endtask

  task automatic idle();
    m0_set(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
    m1_set(1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    m0_set(1'b1, 1'b0, 13'd1, 4'hF, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.mem_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got %b exp 0", bus.mem_chipselect); end
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", bus.mem_write); end
    checks++; if ({bus.m0_readdatavalid, bus.m1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL reset_rdv got %b exp 00", {bus.m0_readdatavalid, bus.m1_readdatavalid}); end
    checks++; if (bus.m0_readdata !== 32'h0 || bus.m1_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0/0", bus.m0_readdata, bus.m1_readdata); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err got %h exp 0", err_count); end
    checks++; if (bus.mem_clken !== 1'b1) begin errors++; $display("FAIL clken got %b exp 1", bus.mem_clken); end
    idle();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Seed RAM through the arbiter: addr1=0x11, addr2=0x22, addr3=0.
  task automatic test_preload();
    logic [31:0] vals [0:2];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m1_set(1'b0, 1'b1, 13'(i + 1), 4'hF, vals[i]);
      #1;
      checks++; if (bus.m1_waitrequest !== 1'b0 || bus.mem_write !== 1'b1) begin errors++; $display("FAIL preload_%0d wr/we got %b/%b exp 0/1", i, bus.m1_waitrequest, bus.mem_write); end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    m0_set(1'b1, 1'b0, 13'd1, 4'hF, 32'h0);
    m1_set(1'b1, 1'b0, 13'd2, 4'hF, 32'h0);
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (bus.m0_waitrequest !== (k % 2 == 1) || bus.m1_waitrequest !== (k % 2 == 0)) begin errors++; $display("FAIL rr_wait_%0d got %b%b exp %b%b", k, bus.m0_waitrequest, bus.m1_waitrequest, k % 2 == 1, k % 2 == 0); end
      checks++; if (bus.mem_address !== ((k % 2 == 0) ? 13'd1 : 13'd2) || bus.mem_chipselect !== 1'b1) begin errors++; $display("FAIL rr_addr_%0d got %0d cs %b", k, bus.mem_address, bus.mem_chipselect); end
      if (k > 0) begin
        checks++;
        if ((k % 2 == 1) ? (bus.m0_readdatavalid !== 1'b1 || bus.m1_readdatavalid !== 1'b0 || bus.m0_readdata !== 32'h11 || bus.m1_readdata !== 32'h0)
                         : (bus.m1_readdatavalid !== 1'b1 || bus.m0_readdatavalid !== 1'b0 || bus.m1_readdata !== 32'h22 || bus.m0_readdata !== 32'h0)) begin
          errors++; $display("FAIL rr_rdv_%0d got v%b%b d %h/%h", k, bus.m0_readdatavalid, bus.m1_readdatavalid, bus.m0_readdata, bus.m1_readdata);
        end
      end
      @(negedge clk);
    end
    idle();
    #1;
    checks++; if (bus.m1_readdatavalid !== 1'b1 || bus.m1_readdata !== 32'h22 || bus.m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rr_tail got v%b%b d %h exp v01 d 22", bus.m0_readdatavalid, bus.m1_readdatavalid, bus.m1_readdata); end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    m0_set(1'b0, 1'b1, 13'h0010, 4'hF, 32'hDEADBEEF);
    #1;
    checks++; if (bus.m0_waitrequest !== 1'b0 || bus.m1_waitrequest !== 1'b0 || bus.mem_write !== 1'b1) begin errors++; $display("FAIL wr_grant got w%b%b we %b exp w00 we 1", bus.m0_waitrequest, bus.m1_waitrequest, bus.mem_write); end
    @(negedge clk);
    m0_set(1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
    #1;
    checks++; if (bus.m0_waitrequest !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_chipselect !== 1'b1) begin errors++; $display("FAIL rd_grant got w%b we %b cs %b", bus.m0_waitrequest, bus.mem_write, bus.mem_chipselect); end
    checks++; if (bus.m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_early got %b exp 0", bus.m0_readdatavalid); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got v%b %h exp v1 deadbeef", bus.m0_readdatavalid, bus.m0_readdata); end
    checks++; if (bus.m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_other got %b exp 0", bus.m1_readdatavalid); end
    @(negedge clk);
    #1;
    checks++; if (bus.m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_pulse got %b exp 0", bus.m0_readdatavalid); end
  endtask

  task automatic test_byte_write();
    @(negedge clk);
    m1_set(1'b0, 1'b1, 13'd3, 4'h5, 32'hAABBCCDD);
    @(negedge clk);
    m1_set(1'b1, 1'b0, 13'd3, 4'hF, 32'h0);
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.m1_readdatavalid !== 1'b1 || bus.m1_readdata !== 32'h00BB00DD) begin errors++; $display("FAIL byte_wr got v%b %h exp v1 00bb00dd", bus.m1_readdatavalid, bus.m1_readdata); end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    m0_set(1'b0, 1'b1, 13'd5000, 4'hF, 32'hCAFEF00D);
    #1;
    checks++; if (bus.mem_chipselect !== 1'b0 || bus.mem_write !== 1'b0 || bus.m0_waitrequest !== 1'b0) begin errors++; $display("FAIL oor_wr got cs %b we %b w %b exp 0 0 0", bus.mem_chipselect, bus.mem_write, bus.m0_waitrequest); end
    @(negedge clk);
    m0_set(1'b1, 1'b0, 13'd8191, 4'hF, 32'h0);
    #1;
    checks++; if (bus.mem_chipselect !== 1'b0 || bus.m0_waitrequest !== 1'b0) begin errors++; $display("FAIL oor_rd got cs %b w %b exp 0 0", bus.mem_chipselect, bus.m0_waitrequest); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== 32'h0) begin errors++; $display("FAIL oor_rdata got v%b %h exp v1 0", bus.m0_readdatavalid, bus.m0_readdata); end
    checks++; if (err_count !== 16'd2) begin errors++; $display("FAIL oor_err got %0d exp 2", err_count); end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    bus_s.m0_write = 1'b1; bus_s.m0_address = 13'd5000; bus_s.m0_byteenable = 4'hF;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      #1;
      checks++; if (err_count_s !== 2'((k < 3) ? k : 3)) begin errors++; $display("FAIL sat_%0d got %0d exp %0d", k, err_count_s, (k < 3) ? k : 3); end
    end
    bus_s.m0_write = 1'b0;
  endtask

  task automatic test_read_write_both();
    @(negedge clk);
    m1_set(1'b1, 1'b1, 13'd4, 4'hF, 32'h00001234);
    #1;
    checks++; if (bus.mem_write !== 1'b1 || bus.mem_chipselect !== 1'b1 || bus.m1_waitrequest !== 1'b0) begin errors++; $display("FAIL rw_grant got we %b cs %b w %b exp 1 1 0", bus.mem_write, bus.mem_chipselect, bus.m1_waitrequest); end
    @(negedge clk);
    m1_set(1'b1, 1'b0, 13'd4, 4'hF, 32'h0);
    #1;
    checks++; if (bus.m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rw_rdv got %b exp 0", bus.m1_readdatavalid); end
    checks++; if (err_count !== 16'd3) begin errors++; $display("FAIL rw_err got %0d exp 3", err_count); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.m1_readdatavalid !== 1'b1 || bus.m1_readdata !== 32'h00001234) begin errors++; $display("FAIL rw_ram got v%b %h exp v1 00001234", bus.m1_readdatavalid, bus.m1_readdata); end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    m0_set(1'b1, 1'b0, 13'd1, 4'hF, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    idle();
    @(negedge clk);
    #1;
    checks++; if (bus.m0_readdatavalid !== 1'b0 || bus.m0_readdata !== 32'h0) begin errors++; $display("FAIL mid_rdv got v%b %h exp v0 0", bus.m0_readdatavalid, bus.m0_readdata); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL mid_err got %0d exp 0", err_count); end
    @(negedge clk);
    reset_n = 1'b1;
    m0_set(1'b1, 1'b0, 13'd1, 4'hF, 32'h0);
    m1_set(1'b1, 1'b0, 13'd2, 4'hF, 32'h0);
    #1;
    checks++; if (bus.m0_waitrequest !== 1'b0 || bus.m1_waitrequest !== 1'b1) begin errors++; $display("FAIL mid_prio got w%b%b exp w01", bus.m0_waitrequest, bus.m1_waitrequest); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (bus.m0_readdatavalid !== 1'b1 || bus.m0_readdata !== 32'h11) begin errors++; $display("FAIL mid_after got v%b %h exp v1 11", bus.m0_readdatavalid, bus.m0_readdata); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus_s.m0_read = 1'b0; bus_s.m0_write = 1'b0; bus_s.m0_address = 13'h0; bus_s.m0_byteenable = 4'h0; bus_s.m0_writedata = 32'h0;
    bus_s.m1_read = 1'b0; bus_s.m1_write = 1'b0; bus_s.m1_address = 13'h0; bus_s.m1_byteenable = 4'h0; bus_s.m1_writedata = 32'h0;
    test_reset();
    test_preload();
    test_round_robin();
    test_write_read();
    test_byte_write();
    test_out_of_range();
    test_saturation();
    test_read_write_both();
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_nios_mem_arbiter.md
Name: led_nios_mem_arbiter

Overview:
- Two-master Avalon-MM arbiter that shares the single-port 32-bit on-chip RAM (5000 words, 13-bit word address, byte enables, 1-cycle read latency) between master 0 (Nios data master) and master 1 (DMA/debug engine).
- Sits between both masters and the RAM port.
- Performs round-robin grant, waitrequest back-pressure, readdatavalid routing and out-of-range protection, and counts errors.

Parameters:
- ADDR_W, 13, word address width.
- DATA_W, 32, data width; byte enable width is DATA_W/8.
- DEPTH, 5000, number of implemented words; addresses >= DEPTH are out of range.
- ERR_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- m0_address / m1_address  in  ADDR_W  word address.
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  DATA_W  write data.
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle.
- m0_readdata / m1_readdata  out  DATA_W  read data.
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  DATA_W/8  RAM byte enables.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable; constant 1.
- mem_readdata  in  DATA_W  RAM q, valid one cycle after address is presented.
- err_count  out  ERR_W  saturating count of out-of-range and illegal accesses.

Behaviour:
- Request definition: reqN = mN_read | mN_write. If both are high, the access is a write, the read is ignored, and the access counts as one error.
- Arbitration:
  - Single register last_grant, reset 1, so m0 wins the first contention.
  - Only one requester: it is granted.
  - Both requesting: grant goes to the master that is not last_grant.
  - last_grant updates to the granted master on every grant.
  - At most one access is granted per cycle.
  - Back-to-back grants are allowed with no idle cycle.
- Waitrequest: mN_waitrequest = reqN & ~grantN, combinational. The master must hold its signals until waitrequest is low. waitrequest is low when no request is present.
- RAM drive, in the grant cycle (combinational mux of the granted master):
  - mem_address and mem_byteenable come from the granted master.
  - mem_chipselect = 1 if in range, 0 otherwise.
  - mem_write = granted write & in range.
  - mem_writedata comes from the granted master.
  - With no grant: mem_chipselect = 0, mem_write = 0; the other mem outputs are don't-care and are driven from m0.
- Out of range (address >= DEPTH):
  - Write: dropped, no RAM access.
  - Read: returns 0 with normal timing.
  - Both cases increment err_count.
- Read pipeline:
  - Register rd_vld/rd_owner/rd_oor, loaded at each accepted read.
  - An accepted read in cycle T gives mN_readdatavalid = 1 in cycle T+1, exactly 1 cycle, routed to rd_owner.
  - Readdata in that cycle is mem_readdata, or 0 if rd_oor.
  - A new read may be accepted in T+1 while the previous readdatavalid is asserted, giving 1 read per cycle of throughput.
  - Readdata of the non-owner master is 0.
- Writes complete in the grant cycle; no response is returned.
- err_count:
  - Increments by 1 per erroneous accepted access.
  - Saturates at all-ones and does not wrap.
  - Only reset clears it.
- Reset values: last_grant = 1, rd_vld = 0, err_count = 0, all readdatavalid = 0, all readdata = 0. mem_chipselect and mem_write are 0 while reset_n is low.
- Reset mid-operation: assertion of reset_n clears a pending rd_vld immediately (asynchronous), so no readdatavalid is ever emitted for a read accepted before reset. Grant restarts from m0 priority.

Test Plan:
- m0 writes 0xDEADBEEF to address 0x0010 with byteenable 0xF, then reads it → waitrequest 0 on both; m0_readdatavalid 1 exactly 1 cycle after the read grant; m0_readdata = 0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 read continuously (addresses 1 and 2, holding 0x11 and 0x22) → grants alternate m0, m1, m0, … starting with m0 after reset; waitrequest is high on the loser each cycle; readdatavalid alternates with 0x11/0x22 routed correctly; one RAM access per cycle.
- Byte write: m1 writes 0xAABBCCDD with byteenable 0x5 over 0x00000000 at address 3, then reads it → returns 0x00BB00DD.
- Out of range: m0 writes address 5000 and then reads address 8191 → mem_chipselect = 0 for both; read returns 0 with valid at T+1; err_count = 2. Force err_count near saturation; further errors hold it at 0xFFFF.
- Read and write asserted together by m1 at address 4 with data 0x1234 → treated as a write; RAM[4] = 0x1234; no readdatavalid; err_count increments by 1.
- m0 read accepted, then reset_n pulled low in the following cycle before the clock edge → no readdatavalid; after release, first contention is granted to m0; err_count = 0.
